// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and defaults for the cache/memory arbiter
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_BLOCK_WORDS = 8;
    localparam int DEF_MEM_LAT     = 4;

endpackage

// File: rtl/cache_arb_pick.sv
// rtl/cache_arb_pick.sv - 2-way request picker; CACHE_ARB_DPRIO_EN selects fixed D priority
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic winner
);

`ifdef CACHE_ARB_DPRIO_EN
    // Fixed priority: D-cache takes every tie, history is irrelevant.
    always_comb begin
        winner = d_req ? PORT_D : PORT_I;
    end
`else
    // Round-robin: on a tie the port that did not win last time goes next.
    always_comb begin
        if (i_req && d_req) begin
            winner = ~last_grant;
        end else if (d_req) begin
            winner = PORT_D;
        end else begin
            winner = PORT_I;
        end
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - I/D cache arbiter sequencing word writes and 8-word block fills
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int MEM_LAT     = DEF_MEM_LAT,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        d_req,
    input  logic        i_wr,
    input  logic        d_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] d_addr,
    input  logic [15:0] i_wdata,
    input  logic [15:0] d_wdata,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic [2:0]  fill_offset,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);

    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_lat
        $error("MEM_LAT out of range 1..8");
    end
    if (BLOCK_WORDS < 1 || BLOCK_WORDS > 8 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_bw
        $error("BLOCK_WORDS must be a power of two up to 8");
    end

    localparam logic [2:0] LAST = 3'(BLOCK_WORDS - 1);

    arb_state_t  state, state_n;
    logic        owner, owner_n;
    logic        last_grant, last_grant_n;
    logic [2:0]  iss, iss_n;
    logic [2:0]  ret, ret_n;
    logic [11:0] base_q, base_n;
    logic        i_gnt_n, d_gnt_n;
    logic        en_n, wr_n;
    logic [15:0] addr_n, wdata_n;
    logic        wdone_i, wdone_d, wdone_i_n, wdone_d_n;

    logic        winner;
    logic        w_wr;
    logic [15:0] w_addr, w_wdata;
    logic        ret_hit, fill_last;

    cache_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign w_wr    = (winner == PORT_D) ? d_wr    : i_wr;
    assign w_addr  = (winner == PORT_D) ? d_addr  : i_addr;
    assign w_wdata = (winner == PORT_D) ? d_wdata : i_wdata;

    // Returned words only count while a fill owns memory; strays elsewhere are dropped.
    assign ret_hit   = ((state == FILL) || (state == DRAIN)) && mem_valid;
    assign fill_last = ret_hit && (ret == LAST);

    assign fill_data    = mem_rdata;
    assign fill_offset  = ret;
    assign i_fill_valid = ret_hit && (owner == PORT_I);
    assign d_fill_valid = ret_hit && (owner == PORT_D);
    assign i_done       = wdone_i || (fill_last && (owner == PORT_I));
    assign d_done       = wdone_d || (fill_last && (owner == PORT_D));

    // Next state plus next values of the registered memory-side and grant outputs.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        iss_n        = iss;
        ret_n        = ret;
        base_n       = base_q;
        i_gnt_n      = i_gnt;
        d_gnt_n      = d_gnt;
        en_n         = 1'b0;
        wr_n         = 1'b0;
        addr_n       = 16'h0000;
        wdata_n      = 16'h0000;
        wdone_i_n    = 1'b0;
        wdone_d_n    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_n      = winner;
                    last_grant_n = winner;
                    base_n       = w_addr[15:4];
                    i_gnt_n      = (winner == PORT_I);
                    d_gnt_n      = (winner == PORT_D);
                    en_n         = 1'b1;
                    iss_n        = 3'd0;
                    ret_n        = 3'd0;
                    if (w_wr) begin
                        state_n   = WRITE;
                        wr_n      = 1'b1;
                        addr_n    = w_addr;
                        wdata_n   = w_wdata;
                        wdone_i_n = (winner == PORT_I);
                        wdone_d_n = (winner == PORT_D);
                    end else begin
                        state_n = FILL;
                        addr_n  = {w_addr[15:4], 3'd0, 1'b0};
                    end
                end
            end
            WRITE: begin
                state_n = IDLE;
                i_gnt_n = 1'b0;
                d_gnt_n = 1'b0;
            end
            FILL: begin
                if (iss == LAST) begin
                    state_n = DRAIN;
                end else begin
                    iss_n  = iss + 3'd1;
                    en_n   = 1'b1;
                    addr_n = {base_q, iss + 3'd1, 1'b0};
                end
            end
            DRAIN: begin
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (ret_hit) begin
            ret_n = ret + 3'd1;
            if (ret == LAST) begin
                state_n = IDLE;
                ret_n   = 3'd0;
                iss_n   = 3'd0;
                i_gnt_n = 1'b0;
                d_gnt_n = 1'b0;
                en_n    = 1'b0;
                addr_n  = 16'h0000;
            end
        end
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= PORT_I;
            last_grant <= PORT_I;
            iss        <= 3'd0;
            ret        <= 3'd0;
            base_q     <= 12'h000;
            i_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            wdone_i    <= 1'b0;
            wdone_d    <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            iss        <= iss_n;
            ret        <= ret_n;
            base_q     <= base_n;
            i_gnt      <= i_gnt_n;
            d_gnt      <= d_gnt_n;
            mem_enable <= en_n;
            mem_wr     <= wr_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
            wdone_i    <= wdone_i_n;
            wdone_d    <= wdone_d_n;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int LAT = 4;

    typedef struct packed {
        logic        port;
        logic [2:0]  off;
        logic [15:0] data;
    } fill_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 0, d_req = 0, i_wr = 0, d_wr = 0;
    logic [15:0] i_addr = 0, d_addr = 0, i_wdata = 0, d_wdata = 0;
    logic        i_gnt, d_gnt, i_fill_valid, d_fill_valid, i_done, d_done;
    logic [2:0]  fill_offset;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_enable, mem_wr, mem_valid;

    logic        stray_valid = 1'b0;
    logic [15:0] stray_data = 16'h0000;
    logic        pv [0:LAT-1];
    logic [15:0] pd [0:LAT-1];

    fill_t sb[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.MEM_LAT(LAT), .BLOCK_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .d_req(d_req), .i_wr(i_wr), .d_wr(d_wr),
        .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_offset(fill_offset), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a ^ 16'hA5C3) + 16'h0101;
    endfunction

    // Memory model: a read strobed in cycle c returns in cycle c+LAT
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= 16'h0000;
            end
        end else begin
            pv[0] <= mem_enable && !mem_wr;
            pd[0] <= mem_f(mem_addr);
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    assign mem_valid = pv[LAT-1] | stray_valid;
    assign mem_rdata = stray_valid ? stray_data : pd[LAT-1];

    // Scoreboard consumer: every presented fill word must match the next expected one
    always @(negedge clk) begin
        fill_t e;
        fill_t a;
        if (rst && (i_fill_valid || d_fill_valid)) begin
            checks++;
            a = '{port: d_fill_valid, off: fill_offset, data: fill_data};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL fill_unexpected got port=%0d off=%0d data=%h expected none", a.port, a.off, a.data);
            end else begin
                e = sb.pop_front();
                if ((a !== e) || (i_fill_valid && d_fill_valid)) begin
                    errors++;
                    $display("FAIL fill_word got port=%0d off=%0d data=%h iv=%0b dv=%0b expected port=%0d off=%0d data=%h",
                             a.port, a.off, a.data, i_fill_valid, d_fill_valid, e.port, e.off, e.data);
                end
            end
        end
    end

    task automatic push_fill(input logic port, input logic [15:0] a);
        for (int k = 0; k < 8; k++)
            sb.push_back('{port: port, off: 3'(k), data: mem_f({a[15:4], 3'(k), 1'b0})});
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        checks++;
        if ({i_gnt, d_gnt, i_fill_valid, d_fill_valid, fill_offset, i_done, d_done,
             mem_addr, mem_wdata, mem_enable, mem_wr} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero outputs expected all 0");
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, mem_enable, i_done, d_done} !== 5'd0) begin
            errors++;
            $display("FAIL reset_hold got %b expected 00000", {i_gnt, d_gnt, mem_enable, i_done, d_done});
        end
        rst = 1'b1;
    endtask

    task automatic test_i_fill;
        logic fv;
        @(negedge clk);
        i_req = 1; i_wr = 0; i_addr = 16'h1234;
        push_fill(1'b0, 16'h1234);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (i_gnt !== (k <= 12) || d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL ifill_gnt cyc=%0d got i=%0b d=%0b expected i=%0b", k, i_gnt, d_gnt, (k <= 12));
            end
            checks++;
            if (mem_enable !== (k <= 8) || (k <= 8 && (mem_wr !== 1'b0 || mem_addr !== 16'h1230 + 16'(2 * (k - 1))))) begin
                errors++;
                $display("FAIL ifill_issue cyc=%0d got en=%0b wr=%0b addr=%h expected en=%0b addr=%h",
                         k, mem_enable, mem_wr, mem_addr, (k <= 8), 16'h1230 + 16'(2 * (k - 1)));
            end
            fv = (k >= 5) && (k <= 12);
            checks++;
            if (i_fill_valid !== fv || (fv && fill_offset !== 3'(k - 5))) begin
                errors++;
                $display("FAIL ifill_ret cyc=%0d got fv=%0b off=%0d expected fv=%0b off=%0d", k, i_fill_valid, fill_offset, fv, k - 5);
            end
            checks++;
            if (i_done !== (k == 12) || d_done !== 1'b0) begin
                errors++;
                $display("FAIL ifill_done cyc=%0d got %0b expected %0b", k, i_done, (k == 12));
            end
            if (k == 12) i_req = 0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ifill_sb_left got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_d_write;
        @(negedge clk);
        d_req = 1; d_wr = 1; d_addr = 16'h00A2; d_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({d_gnt, i_gnt, mem_enable, mem_wr, d_done, i_done} !== 6'b101110 ||
            mem_addr !== 16'h00A2 || mem_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL dwrite_cycle got ctl=%b addr=%h wdata=%h expected ctl=101110 addr=00a2 wdata=beef",
                     {d_gnt, i_gnt, mem_enable, mem_wr, d_done, i_done}, mem_addr, mem_wdata);
        end
        d_req = 0; d_wr = 0;
        @(negedge clk);
        checks++;
        if ({d_gnt, mem_enable, mem_wr, d_done} !== 4'b0000) begin
            errors++;
            $display("FAIL dwrite_after got %b expected 0000", {d_gnt, mem_enable, mem_wr, d_done});
        end
    endtask

    task automatic test_tie;
        logic seq [0:1];
        logic second;
        int   nd;
        nd = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`ifdef CACHE_ARB_DPRIO_EN
        second = 1'b1;
`else
        second = 1'b0;
`endif
        push_fill(1'b1, 16'h8010);
        push_fill(second, second ? 16'h8010 : 16'h4000);
        i_req = 1; i_wr = 0; i_addr = 16'h4000;
        d_req = 1; d_wr = 0; d_addr = 16'h8010;
        for (int k = 1; k <= 80 && nd < 2; k++) begin
            @(negedge clk);
            checks++;
            if (i_gnt && d_gnt) begin
                errors++;
                $display("FAIL tie_exclusive cyc=%0d got both grants expected one", k);
            end
            if (k == 1) begin
                checks++;
                if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_first got d=%0b i=%0b expected d=1 i=0", d_gnt, i_gnt);
                end
            end
            if (i_done || d_done) begin
                seq[nd] = d_done;
                nd++;
                if (nd == 2) begin
                    i_req = 0; d_req = 0;
                end
            end
        end
        checks++;
        if (nd != 2) begin
            errors++;
            $display("FAIL tie_timeout got %0d dones expected 2", nd);
            i_req = 0; d_req = 0;
        end else if (seq[0] !== 1'b1 || seq[1] !== second) begin
            errors++;
            $display("FAIL tie_order got %0d,%0d expected 1,%0d", seq[0], seq[1], second);
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL tie_sb_left got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_write_during_fill;
        @(negedge clk);
        i_req = 1; i_wr = 0; i_addr = 16'h2000;
        push_fill(1'b0, 16'h2000);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                checks++;
                if (mem_addr !== 16'h2000 + 16'(2 * (k - 1))) begin
                    errors++;
                    $display("FAIL wdf_capture cyc=%0d got %h expected %h", k, mem_addr, 16'h2000 + 16'(2 * (k - 1)));
                end
            end
            if (k <= 13) begin
                checks++;
                if (d_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL wdf_dblocked cyc=%0d got d_gnt=%0b expected 0", k, d_gnt);
                end
            end
            if (k == 12) begin
                checks++;
                if (i_done !== 1'b1) begin
                    errors++;
                    $display("FAIL wdf_idone got %0b expected 1", i_done);
                end
            end
            if (k == 13) begin
                checks++;
                if (i_gnt !== 1'b0 || mem_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL wdf_gap got i_gnt=%0b en=%0b expected 0 0", i_gnt, mem_enable);
                end
            end
            if (k == 14) begin
                checks++;
                if ({d_gnt, mem_enable, mem_wr, d_done} !== 4'b1111 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1111) begin
                    errors++;
                    $display("FAIL wdf_write got ctl=%b addr=%h wdata=%h expected 1111 0100 1111",
                             {d_gnt, mem_enable, mem_wr, d_done}, mem_addr, mem_wdata);
                end
                d_req = 0; d_wr = 0;
            end
            if (k == 2) i_addr = 16'hFFFF;
            if (k == 3) begin
                d_req = 1; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'h1111;
            end
            if (k == 5) i_req = 0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wdf_sb_left got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_fill;
        @(negedge clk);
        d_req = 1; d_wr = 0; d_addr = 16'h3000;
        push_fill(1'b1, 16'h3000);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b0;
        d_req = 0;
        #1;
        checks++;
        if ({i_gnt, d_gnt, i_fill_valid, d_fill_valid, fill_offset, i_done, d_done,
             mem_addr, mem_wdata, mem_enable, mem_wr} !== 42'd0) begin
            errors++;
            $display("FAIL rmid_outputs got nonzero outputs expected all 0");
        end
        checks++;
        if (sb.size() != 4) begin
            errors++;
            $display("FAIL rmid_words_before got %0d left expected 4", sb.size());
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        d_req = 1;
        push_fill(1'b1, 16'h3000);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            checks++;
            if (d_gnt !== (k <= 12) || d_done !== (k == 12)) begin
                errors++;
                $display("FAIL rmid_refill cyc=%0d got gnt=%0b done=%0b expected gnt=%0b done=%0b",
                         k, d_gnt, d_done, (k <= 12), (k == 12));
            end
            if (k == 12) d_req = 0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rmid_sb_left got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_stray_valid;
        @(negedge clk);
        stray_valid = 1; stray_data = 16'hDEAD;
        #1;
        checks++;
        if (i_fill_valid !== 1'b0 || d_fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_fv got i=%0b d=%0b expected 0 0", i_fill_valid, d_fill_valid);
        end
        @(negedge clk);
        stray_valid = 0;
        checks++;
        if ({i_gnt, d_gnt, mem_enable, i_done, d_done, fill_offset} !== 8'd0) begin
            errors++;
            $display("FAIL stray_state got %b expected 00000000", {i_gnt, d_gnt, mem_enable, i_done, d_done, fill_offset});
        end
        i_req = 1; i_wr = 1; i_addr = 16'h0002; i_wdata = 16'hCAFE;
        @(negedge clk);
        checks++;
        if ({i_gnt, mem_enable, mem_wr, i_done} !== 4'b1111 || mem_addr !== 16'h0002 || mem_wdata !== 16'hCAFE) begin
            errors++;
            $display("FAIL stray_then_write got ctl=%b addr=%h wdata=%h expected 1111 0002 cafe",
                     {i_gnt, mem_enable, mem_wr, i_done}, mem_addr, mem_wdata);
        end
        i_req = 0; i_wr = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_d_write();
        test_tie();
        test_write_during_fill();
        test_reset_mid_fill();
        test_stray_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
